// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU I/O slice: switch channel count, debounce timing,
// per-channel debounce FSM encoding and a constant-width helper.
package cpu_io_pkg;

  localparam int SW_WIDTH           = 3;
  localparam int SW_DEBOUNCE_CYCLES = 500000;
  localparam int SW_SYNC_STAGES     = 2;

  // Debounce FSM encoding, kept as plain constants so older blocks can share it.
  localparam logic [0:0] SW_ST_IDLE  = 1'b0;
  localparam logic [0:0] SW_ST_COUNT = 1'b1;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: synchroniser chain, stability counter, two-state debounce
// FSM and registered rise/fall strobes aligned with the stable level edge.
module sw_debounce_bit
  import cpu_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       raw,
  output logic       stable,
  output logic       rise,
  output logic       fall,
  output logic [0:0] state
);

  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [0:0]             state_q, state_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;
  logic                   mismatch;
  logic                   cnt_last;

  assign sync     = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync != stable_q);
  assign cnt_last = (cnt_q == CNT_LAST);

  // In IDLE the counter is always 0, so cnt_last there only fires when
  // DEBOUNCE_CYCLES is 1 and the update must happen on the first mismatch.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw};
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      SW_ST_IDLE: begin
        if (mismatch) begin
          if (cnt_last) begin
            stable_d = sync;
            rise_d   = sync;
            fall_d   = ~sync;
            cnt_d    = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SW_ST_COUNT;
          end
        end
      end
      SW_ST_COUNT: begin
        if (!mismatch) begin
          cnt_d   = '0;
          state_d = SW_ST_IDLE;
        end else if (cnt_last) begin
          stable_d = sync;
          rise_d   = sync;
          fall_d   = ~sync;
          cnt_d    = '0;
          state_d  = SW_ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SW_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      state_q  <= SW_ST_IDLE;
      stable_q <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign state  = state_q;

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: WIDTH independent synchronise+debounce channels
// feeding the PIO in_port, plus per-bit edge strobes and a combined change flag.
module sw_debounce
  import cpu_io_pkg::*;
#(
  parameter int               WIDTH           = SW_WIDTH,
  parameter int               SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int               DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic [WIDTH-1:0] dbg_state
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VAL[i])
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i]),
      .state  (dbg_state[i:i])
    );
  end

  // Strobes are already registered, so the OR lines up with them in the same cycle.
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity, every
// cycle compared against a sliding-window model of the debounce rule.
module tb_sw_debounce;

  localparam int W = 3;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;
  logic [W-1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // Model state: raw samples still inside the sync chain, recent synchronised samples.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] sync_hist[$];
  logic [W-1:0] m_stable;
  logic [3*W:0] exp_q[$];
  int           strobe_cnt;
  int           rise2_cnt;

  sw_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(N),
    .RESET_VAL      (3'b000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    raw_hist.push_back('0);
    raw_hist.push_back('0);
    sync_hist.delete();
    m_stable = '0;
  endtask

  // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
  // A bit flips when the last N synchronised samples all differ from its stable level.
  task automatic tick();
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic         all_diff;
    logic [3*W:0] exp;
    @(posedge clk);
    r = '0;
    f = '0;
    if (!reset_n) begin
      model_reset();
    end else begin
      s = raw_hist.pop_front();
      raw_hist.push_back(sw_raw);
      sync_hist.push_back(s);
      if (sync_hist.size() > N) void'(sync_hist.pop_front());
      if (sync_hist.size() == N) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          foreach (sync_hist[j]) if (sync_hist[j][b] == m_stable[b]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_stable[b]) f[b] = 1'b1;
            else r[b] = 1'b1;
            m_stable[b] = ~m_stable[b];
          end
        end
      end
    end
    exp_q.push_back({|(r | f), f, r, m_stable});
    #1;
    exp = exp_q.pop_front();
    check_eq("cycle", {sw_changed, sw_fall, sw_rise, sw_stable}, exp);
    if ((sw_rise | sw_fall) != '0) strobe_cnt++;
    if (sw_rise[2]) rise2_cnt++;
  endtask

  task automatic settle(input logic [W-1:0] value, input int cycles);
    sw_raw = value;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    model_reset();
    strobe_cnt = 0;
    rise2_cnt  = 0;

    // 1. Raw pins high during reset, debounced to 111 after release.
    sw_raw  = 3'b111;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("t1_reset_stable", sw_stable, 3'b000);
    check_eq("t1_reset_strobes", {sw_rise, sw_fall}, 6'b0);
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check_eq("t1_stable_before", sw_stable, 3'b000);
      if (e == 6) begin
        check_eq("t1_stable", sw_stable, 3'b111);
        check_eq("t1_rise", sw_rise, 3'b111);
      end
      if (e == 7) check_eq("t1_rise_gone", sw_rise, 3'b000);
    end

    // 2. Three-cycle glitch on bit0 is rejected.
    settle(3'b000, 10);
    check_eq("t2_start", sw_stable, 3'b000);
    strobe_cnt = 0;
    settle(3'b001, 3);
    settle(3'b000, 10);
    check_eq("t2_stable", sw_stable, 3'b000);
    check_eq("t2_no_strobe", strobe_cnt, 0);

    // 3. Single rise on bit1.
    sw_raw = 3'b010;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 5) check_eq("t3_changed_before", sw_changed, 1'b0);
      if (e == 6) begin
        check_eq("t3_stable", sw_stable, 3'b010);
        check_eq("t3_rise", sw_rise, 3'b010);
        check_eq("t3_changed", sw_changed, 1'b1);
      end
      if (e == 7) check_eq("t3_changed_after", sw_changed, 1'b0);
    end

    // 4. Bit2 bounces for 10 cycles, then a final toggle to high.
    rise2_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sw_raw[2] = ~sw_raw[2];
      tick();
    end
    check_eq("t4_no_rise_bouncing", rise2_cnt, 0);
    sw_raw[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) check_eq("t4_rise_edge", sw_rise[2], 1'b1);
    end
    check_eq("t4_rise_count", rise2_cnt, 1);
    check_eq("t4_stable", sw_stable, 3'b110);

    // Random switch activity, mixing long holds and short glitches.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) sw_raw[$urandom_range(0, W - 1)] ^= 1'b1;
      tick();
    end

    // 5. Simultaneous fall on bit0 and rise on bit2.
    settle(3'b001, 12);
    check_eq("t5_start", sw_stable, 3'b001);
    sw_raw = 3'b100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) begin
        check_eq("t5_fall", sw_fall, 3'b001);
        check_eq("t5_rise", sw_rise, 3'b100);
        check_eq("t5_stable", sw_stable, 3'b100);
      end
    end

    // 6. Reset pulsed while bit0 is mid-count.
    sw_raw = 3'b101;
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_stable", sw_stable, 3'b000);
    check_eq("t6_strobes", {sw_changed, sw_rise, sw_fall}, 7'b0);
    sw_raw = 3'b000;
    for (int i = 0; i < 2; i++) tick();
    reset_n = 1'b1;
    strobe_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_no_strobe", strobe_cnt, 0);
    check_eq("t6_stable_after", sw_stable, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
